// File: rtl/bcd_display_scanner.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Presents one BCD digit at a time to an external 7447-style decoder, drives
// active-low digit selects, and adds frame-synchronous loading, leading-zero
// blanking and per-digit blinking.
module bcd_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [3:0]              bcd_out,
  output logic                    dec_en,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [PW-1:0]             presc;
  logic [IW-1:0]             idx;
  logic [FW-1:0]             frame_cnt;
  logic                      blink_phase;
  logic [4*NUM_DIGITS-1:0]   disp_reg;
  logic [4*NUM_DIGITS-1:0]   pend_reg;
  logic                      pend_valid;

  logic                      tick;
  logic                      wrap;
  logic [3:0]                cur_digit;
  logic                      cur_lz;
  logic                      cur_blink;
  logic                      above_zero;
  logic [NUM_DIGITS-1:0]     sel_next;

  // End of a digit slot, and end of the whole frame when on the last digit
  always_comb begin
    tick = (presc == PRESC_LAST);
    wrap = tick && (idx == IDX_LAST);
  end

  // Pick the current digit's code, leading-zero status, blink enable and select pattern
  always_comb begin
    cur_digit  = 4'd0;
    cur_lz     = 1'b0;
    cur_blink  = 1'b0;
    sel_next   = '1;
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      above_zero = above_zero && (disp_reg[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) begin
        cur_digit   = disp_reg[4*i +: 4];
        cur_lz      = (i > 0) && above_zero;
        cur_blink   = blink_mask[i];
        sel_next[i] = 1'b0;
      end
    end
  end

  // Prescaler and digit index: each digit stays selected for SCAN_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Frame-synchronous loading: new data lands in disp_reg only at a frame wrap, newest wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
    end else if (wrap) begin
      pend_valid <= 1'b0;
      if (load) begin
        disp_reg <= digits_in;
      end else if (pend_valid) begin
        disp_reg <= pend_reg;
      end
    end else if (load) begin
      pend_reg   <= digits_in;
      pend_valid <= 1'b1;
    end
  end

  // Blink phase toggles after every BLINK_DIV completed frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Registered outputs; selects go all-off for one cycle after each slot change to avoid ghosting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out    <= 4'd0;
      dec_en     <= 1'b0;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else begin
      bcd_out    <= cur_digit;
      dec_en     <= !((blank_lz && cur_lz) || (cur_blink && blink_phase));
      digit_sel  <= tick ? '1 : sel_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with directed scenarios followed
// by randomized loads, blanking and blink masks against a cycle-count model.
module tb_bcd_display_scanner;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [3:0]  bcd_out;
  logic        dec_en;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int          testCount = 0;
  int          failCount = 0;

  // Model state: edges since reset release, shown frame, newest pending load
  int          k;
  logic [15:0] mDisp;
  logic [15:0] mLatest;
  bit          mLatestValid;

  logic        curBlz;
  logic [3:0]  curBm;

  bcd_display_scanner #(
    .NUM_DIGITS(N),
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .digits_in (digits_in),
    .blank_lz  (blank_lz),
    .blink_mask(blink_mask),
    .bcd_out   (bcd_out),
    .dec_en    (dec_en),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    k            = 0;
    mDisp        = 16'h0;
    mLatest      = 16'h0;
    mLatestValid = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the registered outputs from the
  // frame/slot position implied by the edge count, then compare.
  task automatic applyStimulus(input logic ld, input logic [15:0] din, input logic blz, input logic [3:0] bm);
    int         slot;
    int         frames;
    bit         tick;
    bit         wrap;
    bit         phase;
    bit         lz;
    logic [3:0] eBcd;
    logic [3:0] eSel;
    logic       eEn;
    load       = ld;
    digits_in  = din;
    blank_lz   = blz;
    blink_mask = bm;
    @(posedge clk);
    tick   = (k % SD) == SD - 1;
    slot   = (k / SD) % N;
    wrap   = tick && (slot == N - 1);
    frames = k / (SD * N);
    phase  = ((frames / BD) % 2) == 1;
    eBcd   = 4'((mDisp >> (4 * slot)) & 16'hF);
    lz     = (slot > 0) && ((mDisp >> (4 * slot)) == 16'h0);
    eEn    = !((blz && lz) || (bm[slot] && phase));
    eSel   = tick ? 4'hF : ~(4'b0001 << slot);
    if (wrap) begin
      if (ld) mDisp = din;
      else if (mLatestValid) mDisp = mLatest;
      mLatestValid = 1'b0;
    end else if (ld) begin
      mLatest      = din;
      mLatestValid = 1'b1;
    end
    k++;
    #1;
    checkOutput("bcd_out", 32'(bcd_out), 32'(eBcd));
    checkOutput("dec_en", 32'(dec_en), 32'(eEn));
    checkOutput("digit_sel", 32'(digit_sel), 32'(eSel));
    checkOutput("frame_done", 32'(frame_done), 32'(wrap));
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, curBlz, curBm);
  endtask

  task automatic loadNow(input logic [15:0] din);
    applyStimulus(1'b1, din, curBlz, curBm);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sel"}, 32'(digit_sel), 32'hF);
    checkOutput({tag, "_en"}, 32'(dec_en), 32'h0);
    checkOutput({tag, "_bcd"}, 32'(bcd_out), 32'h0);
    checkOutput({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    digits_in  = 16'h0;
    blank_lz   = 1'b0;
    blink_mask = 4'h0;
    curBlz     = 1'b0;
    curBm      = 4'h0;
    modelReset();
    #23;
    checkResetOutputs("por");
    #3;
    rst = 1'b0;
    modelReset();

    // Display stays at zero mid-frame, then shows the loaded frame after wrap
    runIdle(6);
    loadNow(16'h1234);
    runIdle(40);

    // Two loads in one frame: only the newest is shown
    loadNow(16'h1111);
    runIdle(3);
    loadNow(16'h5678);
    runIdle(30);

    // Load coincident with the wrap cycle goes straight to the new frame
    while ((k % (SD * N)) != SD * N - 1) runIdle(1);
    loadNow(16'h4321);
    runIdle(20);

    // Leading-zero blanking
    curBlz = 1'b1;
    loadNow(16'h0050);
    runIdle(35);
    loadNow(16'h0000);
    runIdle(35);
    curBlz = 1'b0;

    // Blinking digit 0 over several frames
    curBm = 4'b0001;
    loadNow(16'h9876);
    runIdle(90);

    // Asynchronous reset mid-scan takes effect immediately
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_rst");
    #2;
    rst = 1'b0;
    modelReset();
    runIdle(5);

    // Randomized loads, blanking and blink masks
    for (int c = 0; c < 700; c++) begin
      logic [15:0] d;
      logic        ld;
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d[15:4]  = 12'h0;
        1: d[15:8]  = 8'h0;
        2: d[15:12] = 4'h0;
        default: ;
      endcase
      ld = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) curBlz = 1'($urandom);
      if ($urandom_range(0, 39) == 0) curBm = 4'($urandom);
      applyStimulus(ld, d, curBlz, curBm);
    end

    load = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
